// File: rtl/distance_gray_pkg.sv
// Shared types and helpers for the distance-to-Gray tracker.
//   state_t     : tracker FSM states
//   gray_encode : binary-to-reflected-Gray conversion (up to MAX_GRAY_W bits)
package distance_gray_pkg;

    localparam int unsigned MAX_GRAY_W = 16;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TRACK   = 2'd1,
        CONFIRM = 2'd2
    } state_t;

    function automatic logic [MAX_GRAY_W-1:0] gray_encode(input logic [MAX_GRAY_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/bin_to_gray.sv
// Combinational clamp-and-encode path: distance -> bin -> Gray code.
// Ports:
//   distance : unsigned measured distance (DIST_W bits)
//   bin_c    : distance >> BIN_SHIFT, saturated at 2^GRAY_W-1
//   gray_c   : Gray encoding of bin_c
module bin_to_gray
    import distance_gray_pkg::*;
#(
    parameter int unsigned DIST_W    = 5,
    parameter int unsigned GRAY_W    = 3,
    parameter int unsigned BIN_SHIFT = 2
) (
    input  logic [DIST_W-1:0] distance,
    output logic [GRAY_W-1:0] bin_c,
    output logic [GRAY_W-1:0] gray_c
);

    // Compare in a width that holds both the shifted distance and the clamp value.
    localparam int unsigned CMP_W = (DIST_W > GRAY_W) ? DIST_W : GRAY_W;

    logic [CMP_W-1:0] raw_bin;
    logic [CMP_W-1:0] max_bin;

    assign raw_bin = CMP_W'(distance >> BIN_SHIFT);
    assign max_bin = CMP_W'({GRAY_W{1'b1}});

    // Saturate, then encode.
    always_comb begin
        bin_c  = (raw_bin > max_bin) ? GRAY_W'(max_bin) : GRAY_W'(raw_bin);
        gray_c = GRAY_W'(gray_encode(MAX_GRAY_W'(bin_c)));
    end

endmodule

// File: rtl/distance_gray_tracker.sv
// Debounced distance tracker: quantises a distance into bins and commits a
// new Gray-coded bin only after STABLE_CNT consecutive valid samples agree.
// Ports:
//   clk, rst     : rising-edge clock, asynchronous active-high reset
//   sample_valid : distance is sampled on this edge
//   distance     : unsigned measured distance
//   gray_code    : committed Gray code (registered)
//   gray_valid   : high once a first code has been committed
//   changed      : one-cycle pulse on the edge a code is committed
module distance_gray_tracker
    import distance_gray_pkg::*;
#(
    parameter int unsigned DIST_W     = 5,
    parameter int unsigned GRAY_W     = 3,
    parameter int unsigned BIN_SHIFT  = 2,
    parameter int unsigned STABLE_CNT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [DIST_W-1:0] distance,
    output logic [GRAY_W-1:0] gray_code,
    output logic              gray_valid,
    output logic              changed
);

    state_t            state;
    state_t            state_nxt;
    logic [GRAY_W-1:0] cand;
    logic [GRAY_W-1:0] cand_nxt;
    logic [GRAY_W-1:0] committed;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [CNT_W-1:0]  cnt_inc;
    logic [GRAY_W-1:0] bin_c;
    logic [GRAY_W-1:0] gray_c;
    logic              commit_c;

    bin_to_gray #(
        .DIST_W    (DIST_W),
        .GRAY_W    (GRAY_W),
        .BIN_SHIFT (BIN_SHIFT)
    ) u_bin_to_gray (
        .distance (distance),
        .bin_c    (bin_c),
        .gray_c   (gray_c)
    );

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cand       <= '0;
            cnt        <= '0;
            committed  <= '0;
            gray_code  <= '0;
            gray_valid <= 1'b0;
            changed    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cand    <= cand_nxt;
            cnt     <= cnt_nxt;
            changed <= commit_c;
            if (commit_c) begin
                committed  <= bin_c;
                gray_code  <= gray_c;
                gray_valid <= 1'b1;
            end
        end
    end

    // Next-state logic; invalid cycles leave everything untouched.
    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        cnt_nxt   = cnt;
        commit_c  = 1'b0;
        cnt_inc   = cnt + CNT_W'(1);

        if (sample_valid) begin
            case (state)
                IDLE, CONFIRM: begin
                    if (bin_c == cand) begin
                        if (cnt_inc == CNT_W'(STABLE_CNT)) begin
                            commit_c = 1'b1;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end else if ((state == CONFIRM) && (bin_c == committed)) begin
                        // Distance fell back to the committed bin: drop the candidate.
                        state_nxt = TRACK;
                        cnt_nxt   = '0;
                    end else begin
                        cand_nxt = bin_c;
                        cnt_nxt  = CNT_W'(1);
                        if (STABLE_CNT == 1) begin
                            commit_c = 1'b1;
                        end
                    end
                end
                TRACK: begin
                    if (bin_c != committed) begin
                        state_nxt = CONFIRM;
                        cand_nxt  = bin_c;
                        cnt_nxt   = CNT_W'(1);
                        if (STABLE_CNT == 1) begin
                            commit_c = 1'b1;
                        end
                    end else begin
                        cnt_nxt = '0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase

            // A commit always lands in TRACK with the counter cleared.
            if (commit_c) begin
                state_nxt = TRACK;
                cnt_nxt   = '0;
            end
        end
    end

endmodule

// File: doc/distance_gray_tracker.md
DISTANCE_GRAY_TRACKER -- requirements
Module: distance_gray_tracker

Interface
REQ-001 SHALL have parameter DIST_W, default 5: distance input width in bits.
REQ-002 SHALL have parameter GRAY_W, default 3: Gray output width in bits.
REQ-003 SHALL have parameter BIN_SHIFT, default 2: bin index = distance >> BIN_SHIFT.
REQ-004 SHALL have parameter STABLE_CNT, default 3, legal range 1..15: consecutive equal-bin valid samples required to commit a new code.
REQ-005 SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port sample_valid, input, 1 bit: distance is sampled on this clk edge.
REQ-008 SHALL have port distance, input, DIST_W bits: unsigned measured distance.
REQ-009 SHALL have port gray_code, output, GRAY_W bits: registered, committed Gray code.
REQ-010 SHALL have port gray_valid, output, 1 bit: high once the first code has been committed.
REQ-011 SHALL have port changed, output, 1 bit: one-cycle pulse on the edge gray_code is committed.

Function
REQ-012 SHALL compute raw bin = distance >> BIN_SHIFT, clamped to 2^GRAY_W-1 when it exceeds that value.
REQ-013 SHALL encode the committed bin b as b ^ (b >> 1).
REQ-014 SHALL sample only on edges where sample_valid=1; with sample_valid=0, all state, counters and outputs hold, and changed=0.
REQ-015 SHALL implement an FSM with three states:
- IDLE: nothing committed since reset.
- TRACK: the last sample matched the committed bin.
- CONFIRM: a candidate bin differing from the committed bin is being counted.
REQ-016 IDLE or CONFIRM, sample bin == cand: cnt increments; when cnt reaches STABLE_CNT, commit.
REQ-017 IDLE or CONFIRM, sample bin != cand and != committed bin: cand <= bin, cnt <= 1; commit immediately if STABLE_CNT=1.
REQ-018 CONFIRM, sample bin == committed bin: SHALL abandon the candidate, clear cnt and go to TRACK with no output change.
REQ-019 TRACK, sample bin == committed bin: SHALL stay in TRACK, cnt=0.
REQ-020 TRACK, sample bin != committed bin: SHALL go to CONFIRM with cand <= bin and cnt <= 1; commit immediately if STABLE_CNT=1.
REQ-021 Commit: on the same edge that accepts the qualifying sample, SHALL set gray_code <= gray(cand), gray_valid <= 1, changed <= 1 and state <= TRACK; changed clears on the next edge.
REQ-022 Latency: SHALL make gray_code visible one cycle after the STABLE_CNT-th consecutive qualifying sample is presented.
REQ-023 The cnt width SHALL be 4 bits; cnt never exceeds STABLE_CNT and never wraps.

Reset
REQ-024 While rst=1, asynchronously: state=IDLE, cand=0, cnt=0, gray_code=0, gray_valid=0, changed=0.
REQ-025 Reset asserted mid-CONFIRM SHALL discard the candidate; after release the first valid sample starts a fresh count from IDLE.

Structure
REQ-026 SHALL place the FSM state enum (IDLE, TRACK, CONFIRM) and a bin-to-Gray function in a shared package, distance_gray_pkg.
REQ-027 SHALL isolate the clamp-and-encode path in one sub-module, bin_to_gray, purely combinational and parametrised by DIST_W, GRAY_W and BIN_SHIFT.

Verification (defaults unless stated)
REQ-028 After reset, distance=13 valid for 3 cycles -> gray_code=010, gray_valid=1 and changed pulse one cycle after the 3rd sample; no change after samples 1 and 2.
REQ-029 Committed 13, then distance 30,30,13 -> CONFIRM abandoned, gray_code stays 010, changed never asserts.
REQ-030 Committed 13, then distance 30,20,30,30,30 -> gray_code=100 one cycle after the final 30; candidate restarts at 20 (bin 5).
REQ-031 distance=30 with sample_valid toggling 1,0,1,0,1 -> commit only after the 3rd valid sample; outputs hold on the invalid cycles.
REQ-032 With BIN_SHIFT=1, distance=31 for 3 samples -> bin clamped to 7, gray_code=100.
REQ-033 rst pulsed asynchronously (between edges) during CONFIRM -> all outputs 0 immediately; 3 new samples are needed to commit.
